ddr3_line_buffer: RTL and testbench
===================================

Name: ddr3_line_buffer

Overview:
- Single-line write-combining and read buffer on the ckdr domain.
- Upstream side: the MCS-to-DDR3 adapter issues 32-bit word requests.
- Downstream side: drives the drac_ddr3 256-bit line port (srd/swr/sa/swdat/smsk/srdat/srdy).
- Purpose: merge sequential word writes into one masked line write and serve repeated reads from the held line, cutting DDR3 traffic.

Parameters:
- IDLE_FLUSH, 1023: ckdr cycles a dirty line may sit untouched before an automatic flush; 0 disables the timer.

Ports:
- ckdr  in  1  clock (150 MHz DDR controller clock)
- reset  in  1  asynchronous, active-high reset
- req_rd  in  1  word read request, held until req_ack
- req_wr  in  1  word write request, held until req_ack
- req_flush  in  1  flush request, held until req_ack
- req_addr  in  32  byte address [33:2]; [4:2] selects the word in the line
- req_wdat  in  32  write data
- req_be  in  4  byte enables, 1 = write the byte
- req_rdat  out  32  read data, valid in the req_ack cycle
- req_ack  out  1  one-cycle completion pulse
- srd  out  1  line read request to drac
- swr  out  1  line write request to drac
- sa  out  29  line address [33:5]
- swdat  out  256  line write data
- smsk  out  32  byte mask, 1 = byte NOT written
- srdat  in  256  line read data, valid while srdy=1
- srdy  in  1  one-cycle completion from drac
- dirty  out  1  line holds unflushed bytes (debug)

Behaviour:
- Reset values: all outputs 0; state IDLE; line_valid=0; bytevalid=0; timer=0.
- State after reset mid-operation: any outstanding drac transaction is abandoned, srd/swr drop immediately.
- Line mapping:
  - word w = addr[4:2] occupies line bits [32w+31:32w].
  - req_be[b] maps to bytevalid / smsk bit 4w+b.
- Held-line registers: line_addr[33:5]; line_dat[255:0]; bytevalid[31:0]; line_valid (all 32 bytes match DDR after a fill); dirty = |bytevalid.
- Request priority when several are high: req_flush > req_wr > req_rd. Only one request is serviced per ack.
- States: IDLE, FLUSH, FILL, ACK.
- IDLE, write:
  - If !dirty or req_addr[33:5]==line_addr: merge enabled bytes into line_dat, OR req_be into bytevalid, load line_addr, go ACK. req_ack is asserted the next cycle (latency 1).
  - Otherwise go to FLUSH, then return to IDLE and re-evaluate the write.
- IDLE, read:
  - Hit (line_valid and address match; see optional feature): go ACK, req_rdat = selected word, latency 1.
  - Miss with dirty: go FLUSH, then FILL.
  - Miss with clean line: go FILL.
- IDLE, flush:
  - dirty: go FLUSH, then ACK.
  - clean: go ACK directly.
- FLUSH:
  - Drives swr=1, sa=line_addr, swdat=line_dat, smsk=~bytevalid, all held until srdy.
  - On srdy: bytevalid cleared, line_valid kept.
- FILL:
  - Drives srd=1, sa=req_addr[33:5] until srdy.
  - On srdy: line_dat=srdat, line_addr loaded, line_valid=1, bytevalid=0, then ACK.
  - req_rdat is taken from line_dat in ACK.
- ACK: req_ack=1 for exactly one cycle, then IDLE. The requester must drop its request in the ack cycle.
- A write to a different line clears line_valid for the new line until it is filled.
- srd and swr are never high together. sa/swdat/smsk are stable while either is high.
- Idle timer:
  - Counts IDLE cycles with dirty=1 and no request.
  - On reaching IDLE_FLUSH, enters FLUSH internally with no req_ack.
  - Reset to 0 by any request or by the flush completing.
  - A request arriving in the same cycle the timer expires wins; the timer restarts.
- srdy outside FLUSH/FILL is ignored.

Optional Feature:
- Macro: DDR3_LINE_BUFFER_READ_HIT_EN.
- Defined: reads hitting the held valid line complete from the buffer in 1 cycle.
- Undefined:
  - Every read is a miss: flush if dirty, then FILL, even for the same line.
  - Writes still combine normally.

Test Plan:
- Eight writes, req_addr 0x0000_0020..0x0000_003C (word addresses 0x20..0x3C step 4), be=4'hF, then req_flush -> exactly one swr with sa=1, smsk=32'h0000_0000, swdat word w = written data; 9 req_ack pulses total.
- Write word 3 with be=4'b0101 to line 5, then write to line 6 -> swr with sa=5 and smsk=32'hFFFF_AFFF occurs before the line-6 write acks.
- Read line 7 word 2 with srdat word 2 = 32'hDEADBEEF -> srd, sa=7, req_rdat=32'hDEADBEEF. A second read of word 2 acks in 1 cycle with no srd when DDR3_LINE_BUFFER_READ_HIT_EN is defined; otherwise a new srd is issued.
- One dirty write with IDLE_FLUSH=16 and no further requests -> swr asserted 16 idle cycles later with no req_ack; dirty=0 after srdy.
- Reset asserted while swr is waiting for srdy -> swr=0 and req_ack=0 immediately; after reset, req_flush acks with no swr.

Source files
------------

// File: rtl/ddr3_line_buffer.sv
// Single-line write-combining / read buffer between the MCS word port and the drac_ddr3 256-bit line port.
// Define DDR3_LINE_BUFFER_READ_HIT_EN to serve reads of the held valid line without a DDR3 fill.
`timescale 1ns/1ps

module ddr3_line_buffer #(
    parameter int unsigned IDLE_FLUSH = 1023
) (
    input  logic         ckdr,
    input  logic         reset,
    input  logic         req_rd,
    input  logic         req_wr,
    input  logic         req_flush,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdat,
    input  logic [3:0]   req_be,
    output logic [31:0]  req_rdat,
    output logic         req_ack,
    output logic         srd,
    output logic         swr,
    output logic [28:0]  sa,
    output logic [255:0] swdat,
    output logic [31:0]  smsk,
    input  logic [255:0] srdat,
    input  logic         srdy,
    output logic         dirty
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FILL, S_ACK} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_FL} op_t;

    localparam int unsigned TW       = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
    localparam logic [TW-1:0] TLIM   = TW'(IDLE_FLUSH - 1);
    localparam bit          TIMER_EN = (IDLE_FLUSH != 0);

    state_t         r_state;
    state_t         w_next;
    op_t            r_op;
    op_t            w_op;
    logic [28:0]    r_line_addr;
    logic [255:0]   r_line_dat;
    logic [31:0]    r_bytevalid;
    logic           r_line_valid;
    logic [28:0]    r_req_line;
    logic [2:0]     r_req_word;
    logic [TW-1:0]  r_timer;

    // req_addr carries byte-address bits [33:2]: [2:0] is the word, [31:3] the line
    logic [28:0]    w_req_line;
    logic [2:0]     w_req_word;
    logic           w_any_req;
    logic           w_dirty;
    logic           w_line_match;
    logic           w_rd_hit;
    logic           w_wr_ok;
    logic           w_timer_hit;
    logic [31:0]    w_be_line;
    logic [255:0]   w_wr_mask;

    assign w_req_line   = req_addr[31:3];
    assign w_req_word   = req_addr[2:0];
    assign w_any_req    = req_rd | req_wr | req_flush;
    assign w_dirty      = |r_bytevalid;
    assign w_line_match = (w_req_line == r_line_addr);
    assign w_wr_ok      = !w_dirty || w_line_match;
    assign dirty        = w_dirty;

`ifdef DDR3_LINE_BUFFER_READ_HIT_EN
    assign w_rd_hit = r_line_valid && w_line_match;
`else
    assign w_rd_hit = 1'b0;
`endif

    assign w_timer_hit = TIMER_EN && (r_state == S_IDLE) && w_dirty && !w_any_req
                         && (r_timer == TLIM);

    always_comb begin
        w_op = OP_NONE;
        if (req_flush)   w_op = OP_FL;
        else if (req_wr) w_op = OP_WR;
        else if (req_rd) w_op = OP_RD;
    end

    always_comb begin
        w_wr_mask = '0;
        w_be_line = 32'(req_be) << {w_req_word, 2'b00};
        for (int unsigned i = 0; i < 32; i++) begin
            w_wr_mask[i*8 +: 8] = {8{w_be_line[i]}};
        end
    end

    always_ff @(posedge ckdr or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                case (w_op)
                    OP_FL:   w_next = w_dirty ? S_FLUSH : S_ACK;
                    OP_WR:   w_next = w_wr_ok ? S_ACK : S_FLUSH;
                    OP_RD:   w_next = w_rd_hit ? S_ACK : (w_dirty ? S_FLUSH : S_FILL);
                    default: w_next = w_timer_hit ? S_FLUSH : S_IDLE;
                endcase
            end
            S_FLUSH: begin
                // a displaced write returns to IDLE so the merge is re-evaluated on the clean line
                if (srdy) begin
                    case (r_op)
                        OP_FL:   w_next = S_ACK;
                        OP_RD:   w_next = S_FILL;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_FILL:  if (srdy) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        srd      = 1'b0;
        swr      = 1'b0;
        sa       = '0;
        swdat    = '0;
        smsk     = '0;
        req_ack  = 1'b0;
        req_rdat = '0;
        case (r_state)
            S_FLUSH: begin
                swr   = 1'b1;
                sa    = r_line_addr;
                swdat = r_line_dat;
                smsk  = ~r_bytevalid;
            end
            S_FILL: begin
                srd = 1'b1;
                sa  = r_req_line;
            end
            S_ACK: begin
                req_ack  = 1'b1;
                req_rdat = r_line_dat[{r_req_word, 5'd0} +: 32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge ckdr or posedge reset) begin
        if (reset) begin
            r_op         <= OP_NONE;
            r_line_addr  <= '0;
            r_line_dat   <= '0;
            r_bytevalid  <= '0;
            r_line_valid <= 1'b0;
            r_req_line   <= '0;
            r_req_word   <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_op       <= w_op;
                r_req_line <= w_req_line;
                r_req_word <= w_req_word;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_op == OP_WR && w_wr_ok) begin
                        r_line_dat  <= (r_line_dat & ~w_wr_mask) | ({8{req_wdat}} & w_wr_mask);
                        r_bytevalid <= r_bytevalid | w_be_line;
                        r_line_addr <= w_req_line;
                        if (!w_line_match) r_line_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (srdy) r_bytevalid <= '0;
                end
                S_FILL: begin
                    if (srdy) begin
                        r_line_dat   <= srdat;
                        r_line_addr  <= r_req_line;
                        r_line_valid <= 1'b1;
                        r_bytevalid  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ckdr or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_any_req || (r_state == S_FLUSH && srdy)) begin
            r_timer <= '0;
        end else if (r_state == S_IDLE && w_dirty && !w_timer_hit) begin
            r_timer <= r_timer + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_excl: assert property (@(posedge ckdr) disable iff (reset) !(srd && swr));
    a_wr_stable: assert property (@(posedge ckdr) disable iff (reset)
        (swr && $past(swr)) |-> ($stable(sa) && $stable(smsk) && $stable(swdat)));
    a_rd_stable: assert property (@(posedge ckdr) disable iff (reset)
        (srd && $past(srd)) |-> $stable(sa));
`endif

endmodule

// File: tb/tb_ddr3_line_buffer.sv
// Directed testbench for ddr3_line_buffer with a single-line DDR3 responder model.
`timescale 1ns/1ps

module tb_ddr3_line_buffer;

    logic         ckdr = 1'b0;
    logic         reset;
    logic         req_rd, req_wr, req_flush;
    logic [31:0]  req_addr, req_wdat;
    logic [3:0]   req_be;
    logic [31:0]  req_rdat;
    logic         req_ack;
    logic         srd, swr;
    logic [28:0]  sa;
    logic [255:0] swdat;
    logic [31:0]  smsk;
    logic [255:0] srdat;
    logic         srdy;
    logic         dirty;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int swr_cnt  = 0;
    int srd_cnt  = 0;
    int both_hi  = 0;
    logic [28:0]  last_wr_sa = '0;
    logic [28:0]  last_rd_sa = '0;
    logic [31:0]  last_smsk  = '0;
    logic [255:0] last_swdat = '0;
    logic [255:0] mem_line;
    logic         ddr_hold = 1'b0;

    ddr3_line_buffer #(.IDLE_FLUSH(16)) dut (
        .ckdr(ckdr), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_flush(req_flush),
        .req_addr(req_addr), .req_wdat(req_wdat), .req_be(req_be),
        .req_rdat(req_rdat), .req_ack(req_ack),
        .srd(srd), .swr(swr), .sa(sa), .swdat(swdat), .smsk(smsk),
        .srdat(srdat), .srdy(srdy), .dirty(dirty)
    );

    always #5 ckdr = ~ckdr;

    function automatic logic [255:0] base_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (i == 2) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
        return l;
    endfunction

    // DDR3 responder: answers srd/swr after two cycles, keeps one line of storage
    initial begin
        int wcnt;
        wcnt = 0;
        srdy = 1'b0;
        srdat = '0;
        mem_line = base_line();
        forever begin
            @(negedge ckdr);
            if (srd === 1'b1 && swr === 1'b1) both_hi++;
            if (reset) begin
                srdy = 1'b0;
                wcnt = 0;
                mem_line = base_line();
            end else if (srdy) begin
                srdy = 1'b0;
            end else if ((srd || swr) && !ddr_hold) begin
                wcnt++;
                if (wcnt >= 2) begin
                    wcnt = 0;
                    srdy = 1'b1;
                    if (swr) begin
                        swr_cnt++;
                        last_wr_sa = sa;
                        last_smsk  = smsk;
                        last_swdat = swdat;
                        for (int b = 0; b < 32; b++)
                            if (!smsk[b]) mem_line[b*8 +: 8] = swdat[b*8 +: 8];
                    end else begin
                        srd_cnt++;
                        last_rd_sa = sa;
                        srdat = mem_line;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge ckdr);
            if (req_ack === 1'b1) ack_cnt++;
        end
    end

    task automatic settle();
        @(negedge ckdr);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge ckdr);
        reset = 1'b0;
        settle();
    endtask

    // kind: 0 read, 1 write, 2 flush; lat = cycles to ack, -1 on timeout
    task automatic do_req(input int kind, input logic [33:0] baddr, input logic [31:0] wdat,
                          input logic [3:0] be, output int lat, output logic [31:0] rdat);
        lat  = -1;
        rdat = '0;
        req_rd    = (kind == 0);
        req_wr    = (kind == 1);
        req_flush = (kind == 2);
        req_addr  = baddr[33:2];
        req_wdat  = wdat;
        req_be    = be;
        for (int c = 1; c <= 200; c++) begin
            @(negedge ckdr);
            if (req_ack === 1'b1) begin
                lat  = c;
                rdat = req_rdat;
                break;
            end
        end
        req_rd = 1'b0; req_wr = 1'b0; req_flush = 1'b0;
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL req_timeout: kind %0d addr %h got no req_ack, required one within 200 cycles", kind, baddr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_flush = 1'b0;
        req_addr = '0; req_wdat = '0; req_be = '0;
        settle();
        n_checks++; if (req_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", req_ack); end
        n_checks++; if (srd !== 1'b0) begin n_fail++; $display("FAIL rst_srd: got %b required 0", srd); end
        n_checks++; if (swr !== 1'b0) begin n_fail++; $display("FAIL rst_swr: got %b required 0", swr); end
        n_checks++; if (sa !== 29'h0) begin n_fail++; $display("FAIL rst_sa: got %h required 0", sa); end
        n_checks++; if (smsk !== 32'h0) begin n_fail++; $display("FAIL rst_smsk: got %h required 0", smsk); end
        n_checks++; if (swdat !== 256'h0) begin n_fail++; $display("FAIL rst_swdat: got %h required 0", swdat); end
        n_checks++; if (req_rdat !== 32'h0) begin n_fail++; $display("FAIL rst_rdat: got %h required 0", req_rdat); end
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL rst_dirty: got %b required 0", dirty); end
        apply_reset();
    endtask

    task automatic test_write_combine();
        int lat, ack0, swr0;
        logic [31:0] rd;
        apply_reset();
        ack0 = ack_cnt; swr0 = swr_cnt;
        for (int i = 0; i < 8; i++) begin
            do_req(1, 34'h20 + 34'(i*4), 32'hCAFE_0000 + 32'(i), 4'hF, lat, rd);
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wc_lat%0d: got %0d required 1", i, lat); end
            settle();
        end
        n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL wc_dirty: got %b required 1", dirty); end
        n_checks++; if (swr_cnt - swr0 !== 0) begin n_fail++; $display("FAIL wc_noflush: got %0d swr required 0", swr_cnt - swr0); end
        do_req(2, 34'h0, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (swr_cnt - swr0 !== 1) begin n_fail++; $display("FAIL wc_swr_cnt: got %0d required 1", swr_cnt - swr0); end
        n_checks++; if (last_wr_sa !== 29'd1) begin n_fail++; $display("FAIL wc_sa: got %h required 1", last_wr_sa); end
        n_checks++; if (last_smsk !== 32'h0) begin n_fail++; $display("FAIL wc_smsk: got %h required 00000000", last_smsk); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (last_swdat[i*32 +: 32] !== 32'hCAFE_0000 + 32'(i)) begin
                n_fail++; $display("FAIL wc_swdat%0d: got %h required %h", i, last_swdat[i*32 +: 32], 32'hCAFE_0000 + 32'(i));
            end
        end
        n_checks++; if (ack_cnt - ack0 !== 9) begin n_fail++; $display("FAIL wc_acks: got %0d required 9", ack_cnt - ack0); end
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL wc_clean: got %b required 0", dirty); end
    endtask

    task automatic test_evict();
        int lat, swr0;
        logic [31:0] rd;
        apply_reset();
        swr0 = swr_cnt;
        do_req(1, 34'd5*32 + 34'd12, 32'h1122_3344, 4'b0101, lat, rd);
        settle();
        do_req(1, 34'd6*32, 32'h7777_8888, 4'hF, lat, rd);
        n_checks++; if (swr_cnt - swr0 !== 1) begin n_fail++; $display("FAIL ev_swr_before_ack: got %0d required 1", swr_cnt - swr0); end
        n_checks++; if (lat <= 1) begin n_fail++; $display("FAIL ev_lat: got %0d required >1", lat); end
        n_checks++; if (last_wr_sa !== 29'd5) begin n_fail++; $display("FAIL ev_sa: got %h required 5", last_wr_sa); end
        n_checks++; if (last_smsk !== 32'hFFFF_AFFF) begin n_fail++; $display("FAIL ev_smsk: got %h required FFFFAFFF", last_smsk); end
        n_checks++; if (last_swdat[96 +: 32] !== 32'h0022_0044) begin n_fail++; $display("FAIL ev_swdat: got %h required 00220044", last_swdat[96 +: 32]); end
        settle();
        n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL ev_dirty: got %b required 1", dirty); end
        do_req(2, 34'h0, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (last_wr_sa !== 29'd6) begin n_fail++; $display("FAIL ev_sa6: got %h required 6", last_wr_sa); end
        n_checks++; if (last_smsk !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL ev_smsk6: got %h required FFFFFFF0", last_smsk); end
    endtask

    task automatic test_read();
        int lat, srd0, swr0;
        logic [31:0] rd;
        apply_reset();
        srd0 = srd_cnt;
        do_req(0, 34'd7*32 + 34'd8, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (srd_cnt - srd0 !== 1) begin n_fail++; $display("FAIL rd_srd: got %0d required 1", srd_cnt - srd0); end
        n_checks++; if (last_rd_sa !== 29'd7) begin n_fail++; $display("FAIL rd_sa: got %h required 7", last_rd_sa); end
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h required DEADBEEF", rd); end
        srd0 = srd_cnt;
        do_req(0, 34'd7*32 + 34'd8, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd2_data: got %h required DEADBEEF", rd); end
`ifdef DDR3_LINE_BUFFER_READ_HIT_EN
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd2_hit_lat: got %0d required 1", lat); end
        n_checks++; if (srd_cnt - srd0 !== 0) begin n_fail++; $display("FAIL rd2_hit_srd: got %0d required 0", srd_cnt - srd0); end
`else
        n_checks++; if (srd_cnt - srd0 !== 1) begin n_fail++; $display("FAIL rd2_miss_srd: got %0d required 1", srd_cnt - srd0); end
`endif
        do_req(1, 34'd7*32 + 34'd4, 32'h5A5A_1234, 4'hF, lat, rd);
        settle();
        swr0 = swr_cnt; srd0 = srd_cnt;
        do_req(0, 34'd7*32 + 34'd4, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (rd !== 32'h5A5A_1234) begin n_fail++; $display("FAIL rd_dirty_data: got %h required 5A5A1234", rd); end
`ifdef DDR3_LINE_BUFFER_READ_HIT_EN
        n_checks++; if (swr_cnt - swr0 !== 0) begin n_fail++; $display("FAIL rd_dirty_swr: got %0d required 0", swr_cnt - swr0); end
        n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL rd_dirty_flag: got %b required 1", dirty); end
        do_req(0, 34'd7*32 + 34'd20, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (rd !== 32'hC0DE_0005) begin n_fail++; $display("FAIL rd_w5: got %h required C0DE0005", rd); end
        n_checks++; if (srd_cnt - srd0 !== 0) begin n_fail++; $display("FAIL rd_w5_srd: got %0d required 0", srd_cnt - srd0); end
`else
        n_checks++; if (swr_cnt - swr0 !== 1) begin n_fail++; $display("FAIL rd_dirty_swr: got %0d required 1", swr_cnt - swr0); end
        n_checks++; if (srd_cnt - srd0 !== 1) begin n_fail++; $display("FAIL rd_dirty_srd: got %0d required 1", srd_cnt - srd0); end
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL rd_dirty_flag: got %b required 0", dirty); end
`endif
    endtask

    task automatic test_idle_timer();
        int lat, ack0, swr0, cnt;
        logic [31:0] rd;
        apply_reset();
        ack0 = ack_cnt; swr0 = swr_cnt;
        do_req(1, 34'd3*32, 32'h0BAD_F00D, 4'hF, lat, rd);
        cnt = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge ckdr);
            if (swr === 1'b1) begin cnt = c; break; end
        end
        n_checks++; if (cnt - 1 !== 16) begin n_fail++; $display("FAIL tmr_idle_cycles: got %0d required 16", cnt - 1); end
        for (int c = 0; c < 50 && dirty === 1'b1; c++) @(negedge ckdr);
        settle();
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL tmr_dirty: got %b required 0", dirty); end
        n_checks++; if (swr_cnt - swr0 !== 1) begin n_fail++; $display("FAIL tmr_swr: got %0d required 1", swr_cnt - swr0); end
        n_checks++; if (ack_cnt - ack0 !== 1) begin n_fail++; $display("FAIL tmr_acks: got %0d required 1", ack_cnt - ack0); end
        n_checks++; if (last_wr_sa !== 29'd3) begin n_fail++; $display("FAIL tmr_sa: got %h required 3", last_wr_sa); end
    endtask

    task automatic test_reset_mid_flush();
        int lat, swr0, seen;
        logic [31:0] rd;
        apply_reset();
        do_req(1, 34'd9*32, 32'h1234_5678, 4'hF, lat, rd);
        settle();
        ddr_hold  = 1'b1;
        req_flush = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ckdr);
            if (swr === 1'b1) begin seen = 1; break; end
        end
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL rm_swr_seen: got %0d required 1", seen); end
        repeat (2) @(negedge ckdr);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (swr !== 1'b0) begin n_fail++; $display("FAIL rm_swr_drop: got %b required 0", swr); end
        n_checks++; if (req_ack !== 1'b0) begin n_fail++; $display("FAIL rm_ack: got %b required 0", req_ack); end
        n_checks++; if (srd !== 1'b0) begin n_fail++; $display("FAIL rm_srd: got %b required 0", srd); end
        req_flush = 1'b0;
        @(negedge ckdr);
        reset = 1'b0;
        ddr_hold = 1'b0;
        settle();
        swr0 = swr_cnt;
        do_req(2, 34'h0, 32'h0, 4'h0, lat, rd);
        settle();
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rm_flush_lat: got %0d required 1", lat); end
        n_checks++; if (swr_cnt - swr0 !== 0) begin n_fail++; $display("FAIL rm_flush_swr: got %0d required 0", swr_cnt - swr0); end
    endtask

    initial begin
        test_reset();
        test_write_combine();
        test_evict();
        test_read();
        test_idle_timer();
        test_reset_mid_flush();
        n_checks++; if (both_hi !== 0) begin n_fail++; $display("FAIL srd_swr_overlap: got %0d cycles required 0", both_hi); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
